cam_subarray_write_agent: RTL and testbench

Write agent that sits directly downstream of the CAM data-store controller. It consumes the controller's one-hot `chip_enable`, 10-bit compare address and 16-bit data. For each new request it writes one word into the selected subarray with a timed setup/pulse sequence, then reads the word back and retries on mismatch. It returns a single-cycle `write_ack` that releases the controller, and exposes a registered read port for the downstream search logic.

---
 rtl/cam_subarray_write_agent.sv | 165 ++++++++++++++++
 tb/tb_cam_subarray_write_agent.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/cam_subarray_write_agent.sv
// Write agent for the CAM subarrays: timed setup/pulse write, read-back verify
// with bounded retry, single-cycle ack, sticky error flags and a registered read port.
module cam_subarray_write_agent #(
  parameter int unsigned NUM_BANKS = 16,
  parameter int unsigned ENTRIES   = 32,
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned PULSE_CYC = 2,
  parameter int unsigned MAX_RETRY = 2
) (
  input  logic                             CLK,
  input  logic                             rst,
  input  logic [NUM_BANKS-1:0]             chip_enable,
  input  logic [9:0]                       cmp_addr,
  input  logic [15:0]                      data_in,
  input  logic                             inject_fault,
  input  logic                             clr_err,
  input  logic [$clog2(NUM_BANKS)-1:0]     rd_bank,
  input  logic [$clog2(ENTRIES)-1:0]       rd_index,
  output logic                             write_ack,
  output logic                             write_err,
  output logic                             busy,
  output logic [NUM_BANKS-1:0]             err_bank,
  output logic                             proto_err,
  output logic [15:0]                      rd_data,
  output logic [9-$clog2(ENTRIES):0]       rd_tag,
  output logic                             rd_valid
);
  localparam int unsigned BW = $clog2(NUM_BANKS);
  localparam int unsigned IW = $clog2(ENTRIES);
  localparam int unsigned TW = 10 - IW;

  typedef enum logic [2:0] {IDLE, SETUP, PULSE, VERIFY, ACK} state_t;

  state_t                          state;
  logic [15:0]                     mem_data [NUM_BANKS][ENTRIES];
  logic [TW-1:0]                   mem_tag  [NUM_BANKS][ENTRIES];
  logic [NUM_BANKS-1:0][ENTRIES-1:0] valid;

  logic [NUM_BANKS+9:0] last_served;
  logic [NUM_BANKS-1:0] ce_q;
  logic [BW-1:0]        bank_q, bank_enc;
  logic [IW-1:0]        index_q;
  logic [TW-1:0]        tag_q;
  logic [15:0]          data_q;
  logic                 fault_q;
  logic [7:0]           cnt, attempts;

  logic [15:0]          verify_word;
  logic                 new_req, pe_set, pulse_last, mismatch;
  logic [NUM_BANKS-1:0] err_set;

  assign verify_word = mem_data[bank_q][index_q];
  assign mismatch    = (verify_word != data_q);
  assign pulse_last  = (state == PULSE) && (cnt == 8'(PULSE_CYC - 1));
  assign new_req     = $onehot(chip_enable) && ({chip_enable, cmp_addr} != last_served);
  assign pe_set      = (state == IDLE) && (|chip_enable) && !$onehot(chip_enable);

  always_comb begin
    bank_enc = '0;
    for (int unsigned i = 0; i < NUM_BANKS; i++)
      if (chip_enable[i]) bank_enc = BW'(i);
  end

  always_comb begin
    err_set = '0;
    if (state == VERIFY && mismatch && attempts == 8'(MAX_RETRY)) err_set[bank_q] = 1'b1;
  end

  // Data and tag arrays carry no reset; only the valid bits are cleared.
  always_ff @(posedge CLK) begin
    if (pulse_last) begin
      mem_data[bank_q][index_q] <= data_q ^ {15'b0, fault_q && (attempts == 8'd0)};
      mem_tag[bank_q][index_q]  <= tag_q;
    end
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      write_ack   <= 1'b0;
      write_err   <= 1'b0;
      busy        <= 1'b0;
      proto_err   <= 1'b0;
      err_bank    <= '0;
      last_served <= '0;
      valid       <= '0;
      rd_data     <= '0;
      rd_tag      <= '0;
      rd_valid    <= 1'b0;
      ce_q        <= '0;
      bank_q      <= '0;
      index_q     <= '0;
      tag_q       <= '0;
      data_q      <= '0;
      fault_q     <= 1'b0;
      cnt         <= '0;
      attempts    <= '0;
    end else begin
      rd_data   <= mem_data[rd_bank][rd_index];
      rd_tag    <= mem_tag[rd_bank][rd_index];
      rd_valid  <= valid[rd_bank][rd_index];
      write_ack <= 1'b0;
      write_err <= 1'b0;
      // A new error in the same cycle as clr_err survives the clear.
      err_bank  <= (clr_err ? '0 : err_bank) | err_set;
      if (pe_set)       proto_err <= 1'b1;
      else if (clr_err) proto_err <= 1'b0;

      case (state)
        IDLE: begin
          if (chip_enable == '0) begin
            last_served <= '0;
          end else if (new_req) begin
            ce_q     <= chip_enable;
            bank_q   <= bank_enc;
            index_q  <= cmp_addr[IW-1:0];
            tag_q    <= cmp_addr[9:IW];
            data_q   <= data_in;
            fault_q  <= inject_fault;
            attempts <= '0;
            cnt      <= '0;
            busy     <= 1'b1;
            state    <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == 8'(SETUP_CYC - 1)) begin
            cnt   <= '0;
            state <= PULSE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        PULSE: begin
          if (pulse_last) begin
            valid[bank_q][index_q] <= 1'b1;
            cnt   <= '0;
            state <= VERIFY;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        VERIFY: begin
          if (!mismatch) begin
            write_ack <= 1'b1;
            state     <= ACK;
          end else if (attempts < 8'(MAX_RETRY)) begin
            attempts <= attempts + 8'd1;
            state    <= SETUP;
          end else begin
            write_ack <= 1'b1;
            write_err <= 1'b1;
            state     <= ACK;
          end
        end
        ACK: begin
          last_served <= {ce_q, tag_q, index_q};
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cam_subarray_write_agent.sv
// Directed bench for cam_subarray_write_agent: latency, retry, hard failure,
// protocol error, reset-abort and read-port checks against hand-computed values.
module tb_cam_subarray_write_agent;
  logic        CLK = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] chip_enable = '0;
  logic [9:0]  cmp_addr = '0;
  logic [15:0] data_in = '0;
  logic        inject_fault = 1'b0;
  logic        clr_err = 1'b0;
  logic [3:0]  rd_bank = '0;
  logic [4:0]  rd_index = '0;
  logic        write_ack, write_err, busy, proto_err, rd_valid;
  logic [15:0] err_bank, rd_data;
  logic [4:0]  rd_tag;

  int n_cmp = 0;
  int n_bad = 0;
  int ack_total = 0;
  int n;

  cam_subarray_write_agent #(
    .NUM_BANKS(16), .ENTRIES(32), .SETUP_CYC(1), .PULSE_CYC(2), .MAX_RETRY(2)
  ) dut (
    .CLK(CLK), .rst(rst), .chip_enable(chip_enable), .cmp_addr(cmp_addr),
    .data_in(data_in), .inject_fault(inject_fault), .clr_err(clr_err),
    .rd_bank(rd_bank), .rd_index(rd_index), .write_ack(write_ack),
    .write_err(write_err), .busy(busy), .err_bank(err_bank),
    .proto_err(proto_err), .rd_data(rd_data), .rd_tag(rd_tag), .rd_valid(rd_valid)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) if (write_ack === 1'b1) ack_total++;

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Cycles from the accept edge until write_ack is seen; 99 if the budget expires.
  task automatic wait_ack(output int cycles);
    cycles = 99;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (write_ack === 1'b1) begin
        cycles = k;
        break;
      end
    end
  endtask

  initial begin
    #2 rst = 1'b1;
    #1;
    chk("reset_outputs", {11'b0, write_ack, write_err, busy, proto_err, rd_valid, err_bank},
        32'h0);
    step(); step();
    rst = 1'b0;
    step();

    // Basic write and readback
    chip_enable = 16'h0001; cmp_addr = 10'h2A3; data_in = 16'hBEEF;
    step();
    chk("accept_busy", {31'b0, busy}, 32'd1);
    wait_ack(n);
    chk("basic_latency", n, 32'd4);
    chk("basic_err", {31'b0, write_err}, 32'd0);
    step();
    chk("ack_one_cycle", {30'b0, write_ack, busy}, 32'd0);
    chip_enable = '0; rd_bank = 4'd0; rd_index = 5'd3;
    step();
    chk("basic_rd_data", rd_data, 32'hBEEF);
    chk("basic_rd_tag", rd_tag, 32'h15);
    chk("basic_rd_valid", rd_valid, 32'd1);

    // One-hot walk across all banks, same address
    for (int i = 0; i < 16; i++) begin
      chip_enable = 16'd1 << i; data_in = 16'hA000 + 16'(i);
      step();
      wait_ack(n);
      chk("walk_latency", n, 32'd4);
      step();
    end
    repeat (8) step();
    chk("walk_ack_count", ack_total, 32'd17);
    chk("walk_idle", {31'b0, busy}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      rd_bank = 4'(i); rd_index = 5'd3;
      step();
      chk("walk_rd_data", rd_data, 32'hA000 + i);
      chk("walk_rd_valid", rd_valid, 32'd1);
    end

    // Injected fault on the first attempt -> single retry
    chip_enable = 16'h0004; cmp_addr = 10'h067; data_in = 16'h1234; inject_fault = 1'b1;
    step();
    inject_fault = 1'b0;
    wait_ack(n);
    chk("retry_latency", n, 32'd8);
    chk("retry_err", {31'b0, write_err}, 32'd0);
    step();
    chk("retry_err_bank", err_bank, 32'h0);
    rd_bank = 4'd2; rd_index = 5'd7;
    step();
    chk("retry_rd_data", rd_data, 32'h1234);
    chk("retry_rd_tag", rd_tag, 32'h03);

    // Permanent verify mismatch
    force dut.verify_word = 16'hDEAD;
    chip_enable = 16'h0020; cmp_addr = 10'h0A5; data_in = 16'h5555;
    step();
    wait_ack(n);
    chk("fail_latency", n, 32'd12);
    chk("fail_write_err", {31'b0, write_err}, 32'd1);
    chk("fail_err_bank", err_bank, 32'h0020);
    release dut.verify_word;
    step();
    chk("fail_err_one_cycle", {31'b0, write_err}, 32'd0);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("clr_err_bank", err_bank, 32'h0);
    chip_enable = '0;
    step();

    // Non-one-hot select
    chip_enable = 16'h0003; cmp_addr = 10'h001; data_in = 16'h7777;
    repeat (6) step();
    chk("proto_busy", {31'b0, busy}, 32'd0);
    chk("proto_flag", {31'b0, proto_err}, 32'd1);
    chk("proto_no_ack", ack_total, 32'd19);
    chip_enable = '0;
    step();
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("proto_clear", {31'b0, proto_err}, 32'd0);

    // Reset during the write pulse, then reissue
    chip_enable = 16'h0200; cmp_addr = 10'h11F; data_in = 16'h0F0F;
    rd_bank = 4'd9; rd_index = 5'd31;
    step();
    step();
    #2 rst = 1'b1;
    #1;
    chk("abort_outputs", {29'b0, write_ack, busy, rd_valid}, 32'd0);
    step();
    rst = 1'b0;
    step();
    chk("abort_rd_valid", {31'b0, rd_valid}, 32'd0);
    chk("reissue_busy", {31'b0, busy}, 32'd1);
    wait_ack(n);
    chk("reissue_latency", n, 32'd4);
    step();
    step();
    chk("reissue_rd_data", rd_data, 32'h0F0F);
    chk("reissue_rd_valid", rd_valid, 32'd1);
    chk("total_acks", ack_total, 32'd20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
